ste_dice_bank: RTL and testbench
================================

# ste_dice_bank

Parametrised multi-die roller: N_DICE independent dice with a configurable face count, per-die enable and hold, a timed roll sequence, and a registered result summary (sum, all-equal flag). It sits between the debounced/pulsed trigger path and the seven-segment display logic. It replaces per-die instances with one block that owns the roll sequencing and result aggregation.

## Interface
Parameters:
- N_DICE, 4, number of dice (1..8)
- FACES, 6, faces per die, values 1..FACES (2..15)
- ROLL_CYC, 16, value-update cycles per roll (1..65535)
- VAL_W (localparam), $clog2(FACES+1), width of one die value
- SUM_W (localparam), $clog2(N_DICE*FACES+1), width of the sum

Ports:
- clk  in  1  system clock
- reset_ni  in  1  reset, asynchronous, active-low
- trig_i  in  1  roll request, single-cycle pulse, already synchronised
- en_i  in  N_DICE  per-die enable; a disabled die does not step and is excluded from the result
- hold_i  in  N_DICE  per-die hold; a held die keeps its value during a roll
- val_o  out  N_DICE*VAL_W  die values, die i at [VAL_W*(i+1)-1 -: VAL_W]
- valid_o  out  N_DICE  registered copy of en_i, captured with the result
- sum_o  out  SUM_W  sum of enabled die values
- all_equal_o  out  1  1 when at least 2 dice are enabled and all enabled values are equal
- busy_o  out  1  roll in progress (state != IDLE)
- done_o  out  1  one-cycle pulse: result outputs updated

## Operation
- FSM states: IDLE, ROLL, SUM.
  - IDLE: trig_i=1 -> ROLL; roll counter loaded with ROLL_CYC-1; no die steps on this edge.
  - ROLL: every edge, each die with en_i[i]=1 and hold_i[i]=0 steps; counter decrements; the edge with counter==0 -> SUM.
  - SUM: one edge captures sum_o, all_equal_o and valid_o<=en_i; sets done_o=1 -> IDLE.
- Die step: step_i = (i mod (FACES-1)) + 1; v <= ((v-1+step_i) mod FACES) + 1; always in 1..FACES.
- en_i and hold_i are sampled on every ROLL edge and may change mid-roll.
- trig_i is ignored in ROLL and SUM: no restart, no queuing.
- Sum arithmetic is unsigned in SUM_W bits, with no overflow by construction.
- With fewer than 2 enabled dice, all_equal_o=0. With no dice enabled, sum_o=0.
- Reset values:
  - val_o die i = (i mod FACES)+1
  - sum_o=0, all_equal_o=0, valid_o=0, busy_o=0, done_o=0
  - state=IDLE, counter=0
- Reset asserted mid-roll: all state and outputs take their reset values immediately (asynchronous); no done_o is issued.

## Timing
- trig_i high in cycle 0 (sampled at edge 1) -> busy_o=1 after edge 1.
- Dice update after edges 2..ROLL_CYC+1, exactly ROLL_CYC updates.
- After edge ROLL_CYC+2: sum_o, all_equal_o, valid_o and done_o=1 change together, and busy_o=0.
- done_o is high for exactly one cycle.
- Total latency from the trig_i edge to the result edge: ROLL_CYC+2 edges.
- Back-to-back rolls: trig_i in the cycle where done_o=1 is accepted (state is IDLE).
- Result outputs hold their value until the next SUM edge or reset.
- val_o changes only on ROLL edges or reset.

## Test plan
Defaults N_DICE=4, FACES=6, ROLL_CYC=16 apply to all scenarios.
- Reset release:
  - stimulus: release reset, no trigger.
  - required: val_o=1,2,3,4; sum_o=0; busy_o=0; done_o=0.
- Full roll:
  - stimulus: en_i=1111, hold_i=0, trig_i pulse.
  - required: done_o one cycle, 18 edges after trig; val_o=5,4,3,2; sum_o=14; valid_o=1111; all_equal_o=0.
- Hold and disable:
  - stimulus: from reset; hold_i[1]=1 -> roll.
  - required: val_o=5,2,3,2; sum_o=12.
  - stimulus: from reset; en_i=0111 -> roll.
  - required: sum_o=12; valid_o=0111; die3 stays 4.
- All-equal:
  - stimulus: from reset, en_i=0101, two rolls.
  - required: after roll 1, val_o=5,2,3,4.
  - required: after roll 2, val_o=3,2,3,4; sum_o=6; all_equal_o=1.
- Trigger during roll:
  - stimulus: pulse trig_i at ROLL edge 5.
  - required: exactly one done_o; values identical to the full-roll case (5,4,3,2).
- Reset mid-roll:
  - stimulus: reset_ni low at ROLL edge 8.
  - required: val_o=1,2,3,4 and busy_o=0 immediately; no done_o.
  - stimulus: then a fresh roll.
  - required: sum_o=14.

Source files
------------

// File: rtl/ste_dice_bank.sv
// ste_dice_bank
//
// Multi-die roller. It owns the roll sequencing for N_DICE independent dice
// and registers a result summary of the sum of the enabled dice and an
// all-equal flag.
//
// Ports:
//   clk          system clock
//   reset_ni     asynchronous active-low reset
//   trig_i       roll request, single-cycle pulse, already synchronised
//   en_i         per-die enable; a disabled die does not step and is left out of the result
//   hold_i       per-die hold; a held die keeps its value during a roll
//   val_o        die values, die i at [VAL_W*(i+1)-1 -: VAL_W]
//   valid_o      copy of en_i, captured together with the result
//   sum_o        sum of the enabled die values
//   all_equal_o  1 when at least 2 dice are enabled and all enabled values match
//   busy_o       roll in progress (state != IDLE)
//   done_o       one-cycle pulse: result outputs were just updated
//   state_o      current FSM state, for debug and checkers
//
// Handshake: trig_i is accepted only in IDLE, which includes the cycle in
// which done_o is high. It is dropped while busy_o is high, with no restart
// and no queuing. Each accepted trig_i produces exactly one done_o pulse
// ROLL_CYC+2 edges later, unless reset intervenes.
module ste_dice_bank #(
    parameter int N_DICE   = 4,
    parameter int FACES    = 6,
    parameter int ROLL_CYC = 16,
    localparam int VAL_W   = $clog2(FACES + 1),
    localparam int SUM_W   = $clog2(N_DICE * FACES + 1)
) (
    input  logic                      clk,
    input  logic                      reset_ni,
    input  logic                      trig_i,
    input  logic [N_DICE-1:0]         en_i,
    input  logic [N_DICE-1:0]         hold_i,
    output logic [N_DICE*VAL_W-1:0]   val_o,
    output logic [N_DICE-1:0]         valid_o,
    output logic [SUM_W-1:0]          sum_o,
    output logic                      all_equal_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [1:0]                state_o
);

    localparam int CNT_W = $clog2(ROLL_CYC + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROLL = 2'd1,
        SUM  = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               roll_step;
    logic               capture;

    logic [VAL_W-1:0]   val [N_DICE];

    // Advance a die by s faces, wrapping within 1..FACES. The intermediate
    // value v-1+s is at most 2*FACES-2, which fits in VAL_W+1 bits, so a
    // single conditional subtract replaces the modulo.
    function automatic logic [VAL_W-1:0] step_val(input logic [VAL_W-1:0] v,
                                                  input logic [VAL_W:0]   s);
        logic [VAL_W:0] t;
        t = {1'b0, v} + s - (VAL_W+1)'(1);
        if (t >= (VAL_W+1)'(FACES)) begin
            t = t - (VAL_W+1)'(FACES);
        end
        return VAL_W'(t + (VAL_W+1)'(1));
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        roll_step = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                // The accepting edge only loads the counter; dice start
                // stepping on the next edge.
                if (trig_i) begin
                    state_nx = ROLL;
                    cnt_nx   = CNT_W'(ROLL_CYC - 1);
                end
            end
            ROLL: begin
                roll_step = 1'b1;
                if (cnt == '0) begin
                    state_nx = SUM;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            SUM: begin
                capture  = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy_o  = (state != IDLE);
    assign state_o = state;

    // --------------------------------------------------------------- dice
    for (genvar i = 0; i < N_DICE; i++) begin : g_die
        localparam int STEP = (i % (FACES - 1)) + 1;
        localparam int INIT = (i % FACES) + 1;

        always_ff @(posedge clk or negedge reset_ni) begin
            if (!reset_ni) begin
                val[i] <= VAL_W'(INIT);
            end else if (roll_step && en_i[i] && !hold_i[i]) begin
                val[i] <= step_val(val[i], (VAL_W+1)'(STEP));
            end
        end

        assign val_o[VAL_W*(i+1)-1 -: VAL_W] = val[i];
    end

    // ------------------------------------------------------------ summary
    logic [SUM_W-1:0] sum_c;
    logic [3:0]       n_en;
    logic [VAL_W-1:0] ref_v;
    logic             have_ref;
    logic             mismatch;
    logic             eq_c;

    // The first enabled die is the reference. Any other enabled die that
    // differs from it clears the all-equal flag.
    always_comb begin
        sum_c    = '0;
        n_en     = '0;
        ref_v    = '0;
        have_ref = 1'b0;
        mismatch = 1'b0;
        for (int i = 0; i < N_DICE; i++) begin
            if (en_i[i]) begin
                sum_c = sum_c + SUM_W'(val[i]);
                n_en  = n_en + 4'd1;
                if (!have_ref) begin
                    ref_v    = val[i];
                    have_ref = 1'b1;
                end else if (val[i] != ref_v) begin
                    mismatch = 1'b1;
                end
            end
        end
        eq_c = (n_en >= 4'd2) && !mismatch;
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            sum_o       <= '0;
            all_equal_o <= 1'b0;
            valid_o     <= '0;
            done_o      <= 1'b0;
        end else begin
            done_o <= capture;
            if (capture) begin
                sum_o       <= sum_c;
                all_equal_o <= eq_c;
                valid_o     <= en_i;
            end
        end
    end

endmodule

// File: tb/tb_ste_dice_bank.sv
// Testbench for ste_dice_bank with default parameters (4 dice, 6 faces,
// 16 roll cycles). Expected results are hand-computed and pushed into a
// queue when a roll is issued. A monitor pops and compares them on every
// done_o pulse.
module tb_ste_dice_bank;

    localparam int N_DICE   = 4;
    localparam int FACES    = 6;
    localparam int ROLL_CYC = 16;
    localparam int VAL_W    = 3;
    localparam int SUM_W    = 5;
    localparam int RES_W    = N_DICE + 1 + SUM_W + N_DICE*VAL_W;

    logic                    clk;
    logic                    reset_ni;
    logic                    trig_i;
    logic [N_DICE-1:0]       en_i;
    logic [N_DICE-1:0]       hold_i;
    logic [N_DICE*VAL_W-1:0] val_o;
    logic [N_DICE-1:0]       valid_o;
    logic [SUM_W-1:0]        sum_o;
    logic                    all_equal_o;
    logic                    busy_o;
    logic                    done_o;
    logic [1:0]              state_o;

    logic [RES_W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    ste_dice_bank #(
        .N_DICE   (N_DICE),
        .FACES    (FACES),
        .ROLL_CYC (ROLL_CYC)
    ) dut (
        .clk         (clk),
        .reset_ni    (reset_ni),
        .trig_i      (trig_i),
        .en_i        (en_i),
        .hold_i      (hold_i),
        .val_o       (val_o),
        .valid_o     (valid_o),
        .sum_o       (sum_o),
        .all_equal_o (all_equal_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .state_o     (state_o)
    );

    // ------------------------------------------------ clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------ helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [RES_W-1:0] pack(input int v0, input int v1, input int v2, input int v3,
                                             input int sum, input logic eq, input logic [3:0] valid);
        logic [N_DICE*VAL_W-1:0] v;
        v = {VAL_W'(v3), VAL_W'(v2), VAL_W'(v1), VAL_W'(v0)};
        return {valid, eq, SUM_W'(sum), v};
    endfunction

    // --------------------------------------------------- scoreboard
    always @(negedge clk) begin
        if (reset_ni && done_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done_o), 32'd0);
            end else begin
                logic [RES_W-1:0] e;
                e = exp_q.pop_front();
                check("result", 32'({valid_o, all_equal_o, sum_o, val_o}), 32'(e));
            end
        end
    end

    // ------------------------------------------------------ drivers
    task automatic do_reset();
        @(negedge clk);
        reset_ni = 1'b0;
        trig_i   = 1'b0;
        en_i     = 4'hF;
        hold_i   = 4'h0;
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
    endtask

    // Issue one roll, check busy, latency and done width. extra_at > 0
    // raises trig_i again during the cycle after roll edge extra_at.
    task automatic do_roll(input string name, input logic [3:0] en, input logic [3:0] hold,
                           input logic [RES_W-1:0] exp, input int extra_at);
        int   edges;
        logic got;
        edges = 0;
        got   = 1'b0;
        exp_q.push_back(exp);
        @(negedge clk);
        en_i   = en;
        hold_i = hold;
        trig_i = 1'b1;
        while (!got && edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 1) check({name, "_busy"}, 32'(busy_o), 32'd1);
            if (done_o) got = 1'b1;
            @(negedge clk);
            trig_i = (edges == extra_at);
        end
        trig_i = 1'b0;
        check({name, "_latency"}, 32'(edges), 32'(ROLL_CYC + 2));
        @(posedge clk);
        #1;
        check({name, "_done_width"}, 32'(done_o), 32'd0);
        check({name, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    // ------------------------------------------------------ stimulus
    initial begin
        reset_ni = 1'b0;
        trig_i   = 1'b0;
        en_i     = 4'hF;
        hold_i   = 4'h0;
        repeat (3) @(negedge clk);
        reset_ni = 1'b1;

        // Reset release
        @(negedge clk);
        check("rst_val", 32'(val_o), 32'(pack(1, 2, 3, 4, 0, 1'b0, 4'h0) & 12'hFFF));
        check("rst_sum", 32'(sum_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_eq", 32'(all_equal_o), 32'd0);

        // Full roll
        do_roll("full", 4'hF, 4'h0, pack(5, 4, 3, 2, 14, 1'b0, 4'hF), 0);

        // Hold die 1
        do_reset();
        do_roll("hold", 4'hF, 4'h2, pack(5, 2, 3, 2, 12, 1'b0, 4'hF), 0);

        // Disable die 3
        do_reset();
        do_roll("disable", 4'h7, 4'h0, pack(5, 4, 3, 4, 12, 1'b0, 4'h7), 0);

        // All-equal: dice 0 and 2, two rolls
        do_reset();
        do_roll("eq1", 4'h5, 4'h0, pack(5, 2, 3, 4, 8, 1'b0, 4'h5), 0);
        do_roll("eq2", 4'h5, 4'h0, pack(3, 2, 3, 4, 6, 1'b1, 4'h5), 0);

        // Trigger during roll is ignored
        do_reset();
        do_roll("midtrig", 4'hF, 4'h0, pack(5, 4, 3, 2, 14, 1'b0, 4'hF), 5);
        repeat (25) @(negedge clk);

        // Reset mid-roll
        do_reset();
        @(negedge clk);
        en_i   = 4'hF;
        trig_i = 1'b1;
        @(negedge clk);
        trig_i = 1'b0;
        repeat (8) @(negedge clk);
        reset_ni = 1'b0;
        #1;
        check("midrst_val", 32'(val_o), 32'(pack(1, 2, 3, 4, 0, 1'b0, 4'h0) & 12'hFFF));
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_done", 32'(done_o), 32'd0);
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
        repeat (25) @(negedge clk);
        check("midrst_sum", 32'(sum_o), 32'd0);

        // Fresh roll after the interrupted one
        do_roll("fresh", 4'hF, 4'h0, pack(5, 4, 3, 2, 14, 1'b0, 4'hF), 0);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
